// File: rtl/sgpr_file_if.sv
// Request/response bus of the scalar register file.
// The issue side uses the master modport, the register file the slave modport.
interface sgpr_file_if #(
    parameter int RD_PORT_CNT = 2,
    parameter int ADDR_W      = 12
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_op;
    logic [RD_PORT_CNT*ADDR_W-1:0] req_addr;
    logic [31:0]                   req_base;
    logic [63:0]                   req_val;
    logic                          req_wide;
    logic                          req_scc;
    logic                          resp_valid;
    logic                          resp_ready;
    logic                          resp_op;
    logic                          resp_scc;
    logic [RD_PORT_CNT*64-1:0]     resp_val;
    logic                          resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_base, req_val, req_wide, req_scc,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_op, resp_scc, resp_val, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_base, req_val, req_wide, req_scc,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_op, resp_scc, resp_val, resp_err
    );
endinterface

// File: rtl/sgpr_file.sv
// Scalar register file (SGPR) for the scalar pipeline.
// Reads return RD_PORT_CNT 64-bit register pairs plus SCC; writes store 32 or
// 64 bits at the port 0 address and update SCC. One-entry response buffer with
// valid/ready on both sides. After reset the storage is cleared one entry per
// cycle before any request is accepted.
// Optional feature: define SGPR_BOUNDS_CHECK_EN to flag and suppress accesses
// whose pair would run past the top of the file instead of wrapping.
module sgpr_file #(
    parameter int RD_PORT_CNT = 2,
    parameter int SGPR_DEPTH  = 1024,
    parameter int ADDR_W      = 12
) (
    input logic       clk,
    input logic       rst,
    sgpr_file_if.slave bus
);
    localparam int IDX_W = $clog2(SGPR_DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [IDX_W-1:0]          init_cnt_q;
    logic                      init_last;
    logic [31:0]               mem [SGPR_DEPTH];
    logic                      scc_q;

    logic                      accept;
    logic [IDX_W-1:0]          eff [RD_PORT_CNT];
    logic [IDX_W-1:0]          hi  [RD_PORT_CNT];
    logic [RD_PORT_CNT-1:0]    oob;
    logic [RD_PORT_CNT*64-1:0] rd_val;
    logic                      rd_err;
    logic                      wr_blocked;

    logic                      resp_valid_q;
    logic                      resp_op_q;
    logic                      resp_scc_q;
    logic [RD_PORT_CNT*64-1:0] resp_val_q;
    logic                      resp_err_q;

    assign init_last = (init_cnt_q == IDX_W'(SGPR_DEPTH - 1));

    // A new request may enter whenever the response slot is empty or being drained.
    assign bus.req_ready = !rst && (state_q == ST_RUN) && (!resp_valid_q || bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_op    = resp_op_q;
    assign bus.resp_scc   = resp_scc_q;
    assign bus.resp_val   = resp_val_q;
    assign bus.resp_err   = resp_err_q;

    // State register: reset always restarts the clearing walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave INIT once the last entry has been cleared; RUN is terminal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_last) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Clearing counter walks every entry exactly once while in INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + IDX_W'(1);
        end
    end

    // Per-port effective index, wrapped upper index and range flag.
    always_comb begin
        for (int p = 0; p < RD_PORT_CNT; p++) begin
            eff[p] = IDX_W'(bus.req_base + 32'(bus.req_addr[p*ADDR_W +: ADDR_W]));
            hi[p]  = eff[p] + IDX_W'(1);
`ifdef SGPR_BOUNDS_CHECK_EN
            oob[p] = ({2'b00, bus.req_base} + 34'(bus.req_addr[p*ADDR_W +: ADDR_W]) + 34'd1)
                     >= 34'(SGPR_DEPTH);
`else
            oob[p] = 1'b0;
`endif
        end
    end

    assign rd_err     = |oob;
    assign wr_blocked = oob[0];

    // Read pairs are taken from storage as it stands before this edge's write.
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < RD_PORT_CNT; p++) begin
            if (!oob[p]) begin
                rd_val[p*64 +: 64] = {mem[hi[p]], mem[eff[p]]};
            end
        end
    end

    // Storage: cleared by the INIT walk, otherwise written by accepted writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem[init_cnt_q] <= '0;
            end else if (accept && bus.req_op && !wr_blocked) begin
                mem[eff[0]] <= bus.req_val[31:0];
                if (bus.req_wide) begin
                    mem[hi[0]] <= bus.req_val[63:32];
                end
            end
        end
    end

    // Response slot and SCC: load on accept, drop valid on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_op_q    <= 1'b0;
            resp_scc_q   <= 1'b0;
            resp_val_q   <= '0;
            resp_err_q   <= 1'b0;
            scc_q        <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_op_q    <= bus.req_op;
            if (bus.req_op) begin
                resp_val_q <= '0;
                resp_err_q <= wr_blocked;
                if (wr_blocked) begin
                    resp_scc_q <= scc_q;
                end else begin
                    resp_scc_q <= bus.req_scc;
                    scc_q      <= bus.req_scc;
                end
            end else begin
                resp_val_q <= rd_val;
                resp_scc_q <= scc_q;
                resp_err_q <= rd_err;
            end
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end
endmodule
